// File: rtl/fc_seq_ctrl.sv
// Read/MAC/writeback sequencer for the LeNet FC1 (800->500) and FC2 (500->10) layers.
// Optional macro FC_PERF_CNT_EN adds a perf_cycles busy-cycle counter output.
module fc_seq_ctrl #(
   parameter int FC1_IN_WORDS      = 40,
   parameter int FC1_OUT           = 500,
   parameter int FC2_IN_WORDS      = 25,
   parameter int FC2_OUT           = 10,
   parameter int FC2_W_BASE        = 20000,
   parameter int MAC_LAT           = 2,
   parameter int WEIGHT_ADDR_WIDTH = 15
) (
   input  logic                         clk,
   input  logic                         srst,
   input  logic                         conv_done,
   input  logic                         mem_sel,
   output logic [1:0]                   in_sel,
   output logic [9:0]                   sram_raddr_in,
   output logic [WEIGHT_ADDR_WIDTH-1:0] sram_raddr_weight,
   output logic                         mac_valid,
   output logic                         mac_first,
   output logic                         mac_last,
   output logic [4:0]                   sram_write_enable_e,
   output logic [3:0]                   sram_bytemask_e,
   output logic [9:0]                   sram_waddr_e,
   output logic                         sram_write_enable_f,
   output logic [3:0]                   sram_bytemask_f,
   output logic [9:0]                   sram_waddr_f,
   output logic                         fc1_done,
   output logic                         fc2_done,
   output logic                         busy
`ifdef FC_PERF_CNT_EN
   ,
   output logic [31:0]                  perf_cycles
`endif
);

   localparam int DW  = $clog2(MAC_LAT + 1);
   localparam int WAW = WEIGHT_ADDR_WIDTH;

   typedef enum logic [2:0] {
      IDLE,
      FC1_RUN,
      FC1_DRAIN,
      FC2_RUN,
      FC2_DRAIN
   } state_t;

   state_t           state_q;
   logic [5:0]       beat_q;
   logic [8:0]       neuron_q;
   logic [DW-1:0]    drain_q;
   logic [1:0]       inSel_q;
   logic [9:0]       raddrIn_q;
   logic [WAW-1:0]   raddrW_q;
   logic             macValid_q;
   logic             macFirst_q;
   logic             macLast_q;
   logic [4:0]       weE_q;
   logic [3:0]       maskE_q;
   logic [9:0]       waddrE_q;
   logic             weF_q;
   logic [3:0]       maskF_q;
   logic [9:0]       waddrF_q;
   logic             fc1Done_q;
   logic             fc2Done_q;
   logic             busy_q;

   // {valid, phase, neuron} for neurons whose last beat has been issued but not yet written back
   logic [MAC_LAT-1:0] pipeValid_q;
   logic [MAC_LAT-1:0] pipeFc2_q;
   logic [8:0]         pipeNeuron_q [MAC_LAT];

   logic       fc2Phase;
   logic       beatLast;
   logic       neuronLast;
   logic       wbValid;
   logic       wbFc2;
   logic [8:0] wbNeuron;
   logic [6:0] wbWord;
   logic [2:0] wbBank;
   logic [1:0] wbLane;
   logic [3:0] laneMask;
   logic [4:0] weE_d;
   logic [3:0] maskE_d;
   logic [9:0] waddrE_d;
   logic       weF_d;
   logic [3:0] maskF_d;
   logic [9:0] waddrF_d;

   always_comb begin
      fc2Phase   = (state_q == FC2_RUN);
      beatLast   = fc2Phase ? (beat_q == 6'(FC2_IN_WORDS - 1)) : (beat_q == 6'(FC1_IN_WORDS - 1));
      neuronLast = fc2Phase ? (neuron_q == 9'(FC2_OUT - 1)) : (neuron_q == 9'(FC1_OUT - 1));
   end

   // Four neurons share one 32-bit word, MSB lane first; FC1 words stripe across e0..e4.
   always_comb begin
      wbValid  = pipeValid_q[MAC_LAT-1];
      wbFc2    = pipeFc2_q[MAC_LAT-1];
      wbNeuron = pipeNeuron_q[MAC_LAT-1];
      wbWord   = wbNeuron[8:2];
      wbBank   = 3'(wbWord % 7'd5);
      wbLane   = 2'd3 - wbNeuron[1:0];
      laneMask = ~(4'b0001 << wbLane);
      weE_d    = 5'h1F;
      maskE_d  = 4'hF;
      waddrE_d = waddrE_q;
      weF_d    = 1'b1;
      maskF_d  = 4'hF;
      waddrF_d = waddrF_q;
      if (wbValid && !wbFc2) begin
         weE_d    = ~(5'b00001 << wbBank);
         maskE_d  = laneMask;
         waddrE_d = 10'(wbWord / 7'd5);
      end
      if (wbValid && wbFc2) begin
         weF_d    = 1'b0;
         maskF_d  = laneMask;
         waddrF_d = 10'(wbWord);
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         state_q     <= IDLE;
         beat_q      <= '0;
         neuron_q    <= '0;
         drain_q     <= '0;
         inSel_q     <= 2'd0;
         raddrIn_q   <= '0;
         raddrW_q    <= '0;
         macValid_q  <= 1'b0;
         macFirst_q  <= 1'b0;
         macLast_q   <= 1'b0;
         weE_q       <= 5'h1F;
         maskE_q     <= 4'hF;
         waddrE_q    <= '0;
         weF_q       <= 1'b1;
         maskF_q     <= 4'hF;
         waddrF_q    <= '0;
         fc1Done_q   <= 1'b0;
         fc2Done_q   <= 1'b0;
         busy_q      <= 1'b0;
         pipeValid_q <= '0;
         pipeFc2_q   <= '0;
         for (int i = 0; i < MAC_LAT; i++) begin
            pipeNeuron_q[i] <= '0;
         end
      end else begin
         macValid_q <= 1'b0;
         macFirst_q <= 1'b0;
         macLast_q  <= 1'b0;
         weE_q      <= weE_d;
         maskE_q    <= maskE_d;
         waddrE_q   <= waddrE_d;
         weF_q      <= weF_d;
         maskF_q    <= maskF_d;
         waddrF_q   <= waddrF_d;
         for (int i = MAC_LAT - 1; i > 0; i--) begin
            pipeValid_q[i]  <= pipeValid_q[i-1];
            pipeFc2_q[i]    <= pipeFc2_q[i-1];
            pipeNeuron_q[i] <= pipeNeuron_q[i-1];
         end
         pipeValid_q[0] <= 1'b0;

         case (state_q)
            IDLE: begin
               if (conv_done) begin
                  state_q   <= FC1_RUN;
                  busy_q    <= 1'b1;
                  fc1Done_q <= 1'b0;
                  fc2Done_q <= 1'b0;
                  inSel_q   <= mem_sel ? 2'd0 : 2'd1;
                  beat_q    <= '0;
                  neuron_q  <= '0;
                  raddrIn_q <= '0;
                  raddrW_q  <= '0;
               end
            end
            FC1_RUN, FC2_RUN: begin
               macValid_q <= 1'b1;
               macFirst_q <= (beat_q == 6'd0);
               macLast_q  <= beatLast;
               if (beatLast) begin
                  pipeValid_q[0]  <= 1'b1;
                  pipeFc2_q[0]    <= fc2Phase;
                  pipeNeuron_q[0] <= neuron_q;
                  beat_q          <= '0;
                  raddrIn_q       <= '0;
                  if (neuronLast) begin
                     state_q  <= fc2Phase ? FC2_DRAIN : FC1_DRAIN;
                     neuron_q <= '0;
                     drain_q  <= '0;
                  end else begin
                     neuron_q <= neuron_q + 9'd1;
                     raddrW_q <= raddrW_q + WAW'(1);
                  end
               end else begin
                  beat_q    <= beat_q + 6'd1;
                  raddrIn_q <= 10'(beat_q + 6'd1);
                  raddrW_q  <= raddrW_q + WAW'(1);
               end
            end
            FC1_DRAIN: begin
               drain_q <= drain_q + 1'b1;
               if (drain_q == DW'(MAC_LAT)) begin
                  state_q   <= FC2_RUN;
                  fc1Done_q <= 1'b1;
                  inSel_q   <= 2'd2;
                  beat_q    <= '0;
                  neuron_q  <= '0;
                  raddrIn_q <= '0;
                  raddrW_q  <= WAW'(FC2_W_BASE);
               end
            end
            FC2_DRAIN: begin
               drain_q <= drain_q + 1'b1;
               if (drain_q == DW'(MAC_LAT)) begin
                  state_q   <= IDLE;
                  fc2Done_q <= 1'b1;
                  busy_q    <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef FC_PERF_CNT_EN
   logic [31:0] perf_q;

   always_ff @(posedge clk) begin
      if (srst) begin
         perf_q <= '0;
      end else if (state_q == IDLE && conv_done) begin
         perf_q <= '0;
      end else if (busy_q) begin
         perf_q <= perf_q + 32'd1;
      end
   end

   assign perf_cycles = perf_q;
`endif

   assign in_sel              = inSel_q;
   assign sram_raddr_in       = raddrIn_q;
   assign sram_raddr_weight   = raddrW_q;
   assign mac_valid           = macValid_q;
   assign mac_first           = macFirst_q;
   assign mac_last            = macLast_q;
   assign sram_write_enable_e = weE_q;
   assign sram_bytemask_e     = maskE_q;
   assign sram_waddr_e        = waddrE_q;
   assign sram_write_enable_f = weF_q;
   assign sram_bytemask_f     = maskF_q;
   assign sram_waddr_f        = waddrF_q;
   assign fc1_done            = fc1Done_q;
   assign fc2_done            = fc2Done_q;
   assign busy                = busy_q;

endmodule

// File: tb/tb_fc_seq_ctrl.sv
// Directed bench for fc_seq_ctrl: full FC1/FC2 pass, writeback map, ignored starts, restart and mid-run reset.
module tb_fc_seq_ctrl;

   logic        clk = 1'b0;
   logic        srst;
   logic        conv_done;
   logic        mem_sel;
   logic [1:0]  in_sel;
   logic [9:0]  sram_raddr_in;
   logic [14:0] sram_raddr_weight;
   logic        mac_valid;
   logic        mac_first;
   logic        mac_last;
   logic [4:0]  sram_write_enable_e;
   logic [3:0]  sram_bytemask_e;
   logic [9:0]  sram_waddr_e;
   logic        sram_write_enable_f;
   logic [3:0]  sram_bytemask_f;
   logic [9:0]  sram_waddr_f;
   logic        fc1_done;
   logic        fc2_done;
   logic        busy;
`ifdef FC_PERF_CNT_EN
   logic [31:0] perf_cycles;
`endif

   int nCompared   = 0;
   int nMismatched = 0;

   fc_seq_ctrl dut (
      .clk(clk),
      .srst(srst),
      .conv_done(conv_done),
      .mem_sel(mem_sel),
      .in_sel(in_sel),
      .sram_raddr_in(sram_raddr_in),
      .sram_raddr_weight(sram_raddr_weight),
      .mac_valid(mac_valid),
      .mac_first(mac_first),
      .mac_last(mac_last),
      .sram_write_enable_e(sram_write_enable_e),
      .sram_bytemask_e(sram_bytemask_e),
      .sram_waddr_e(sram_waddr_e),
      .sram_write_enable_f(sram_write_enable_f),
      .sram_bytemask_f(sram_bytemask_f),
      .sram_waddr_f(sram_waddr_f),
      .fc1_done(fc1_done),
      .fc2_done(fc2_done),
      .busy(busy)
`ifdef FC_PERF_CNT_EN
      ,
      .perf_cycles(perf_cycles)
`endif
   );

   always #5 clk = ~clk;

   // Outputs are sampled 1 time unit after the rising edge, inputs change at the same point.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic cd, input logic ms);
      conv_done = cd;
      mem_sel   = ms;
      tick();
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCompared++;
      assert (obs === exp) else begin
         nMismatched++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_in_sel"}, 32'(in_sel), 32'd0);
      checkOutput({tag, "_raddr_in"}, 32'(sram_raddr_in), 32'd0);
      checkOutput({tag, "_raddr_w"}, 32'(sram_raddr_weight), 32'd0);
      checkOutput({tag, "_mac"}, 32'({mac_valid, mac_first, mac_last}), 32'd0);
      checkOutput({tag, "_we_e"}, 32'(sram_write_enable_e), 32'h1F);
      checkOutput({tag, "_mask_e"}, 32'(sram_bytemask_e), 32'hF);
      checkOutput({tag, "_waddr_e"}, 32'(sram_waddr_e), 32'd0);
      checkOutput({tag, "_we_f"}, 32'(sram_write_enable_f), 32'd1);
      checkOutput({tag, "_mask_f"}, 32'(sram_bytemask_f), 32'hF);
      checkOutput({tag, "_waddr_f"}, 32'(sram_waddr_f), 32'd0);
      checkOutput({tag, "_flags"}, 32'({fc1_done, fc2_done, busy}), 32'd0);
`ifdef FC_PERF_CNT_EN
      checkOutput({tag, "_perf"}, perf_cycles, 32'd0);
`endif
   endtask

   initial begin
      int errAddr, errMac, errWr, errFlags, errIdle, nWrE, nWrF;
      int ge, gf, v, n, w;
      logic expValid, expFirst, expLast, expWeF;
      logic [4:0] expWeE;
      logic [3:0] expMaskE, expMaskF;
      logic [9:0] expWaddrE, expWaddrF;

      errAddr = 0; errMac = 0; errWr = 0; errFlags = 0; errIdle = 0; nWrE = 0; nWrF = 0;
      srst = 1'b1; conv_done = 1'b0; mem_sel = 1'b0;
      tick();
      tick();
      checkResetState("por");
      srst = 1'b0;

      // Start with bank group c selected; mem_sel then flips to show it was latched.
      applyStimulus(1'b1, 1'b1);
      conv_done = 1'b0;
      mem_sel   = 1'b0;
      checkOutput("start_busy", 32'(busy), 32'd1);

      // Cycle g counts from the first FC1 address: FC1 run 0..19999, drain 20000..20002,
      // FC2 run 20003..20252, drain 20253..20255, idle from 20256.
      for (int g = 0; g <= 20260; g++) begin
         if (g < 20000) begin
            if (sram_raddr_in !== 10'(g % 40) || sram_raddr_weight !== 15'(g) || in_sel !== 2'd0) errAddr++;
         end else if (g >= 20003 && g < 20253) begin
            gf = g - 20003;
            if (sram_raddr_in !== 10'(gf % 25) || sram_raddr_weight !== 15'(20000 + gf) || in_sel !== 2'd2) errAddr++;
         end

         v = g - 1;
         expValid = 1'b0; expFirst = 1'b0; expLast = 1'b0;
         if (v >= 0 && v < 20000) begin
            expValid = 1'b1; expFirst = (v % 40 == 0); expLast = (v % 40 == 39);
         end else if (v >= 20003 && v < 20253) begin
            expValid = 1'b1; expFirst = ((v - 20003) % 25 == 0); expLast = ((v - 20003) % 25 == 24);
         end
         if ({mac_valid, mac_first, mac_last} !== {expValid, expFirst, expLast}) errMac++;

         expWeE = 5'h1F; expMaskE = 4'hF; expWeF = 1'b1; expMaskF = 4'hF;
         expWaddrE = sram_waddr_e; expWaddrF = sram_waddr_f;
         ge = g - 3;
         if (ge >= 0 && ge < 20000 && ge % 40 == 39) begin
            n = ge / 40; w = n / 4;
            expWeE = ~(5'd1 << (w % 5)); expMaskE = ~(4'd1 << (3 - n % 4)); expWaddrE = 10'(w / 5);
         end
         if (ge >= 20003 && ge < 20253 && (ge - 20003) % 25 == 24) begin
            n = (ge - 20003) / 25; w = n / 4;
            expWeF = 1'b0; expMaskF = ~(4'd1 << (3 - n % 4)); expWaddrF = 10'(w);
         end
         if (sram_write_enable_e !== expWeE || sram_bytemask_e !== expMaskE || sram_waddr_e !== expWaddrE ||
             sram_write_enable_f !== expWeF || sram_bytemask_f !== expMaskF || sram_waddr_f !== expWaddrF) errWr++;
         if (sram_write_enable_e !== 5'h1F) nWrE++;
         if (sram_write_enable_f !== 1'b1) nWrF++;

         if (busy !== (g < 20256) || fc1_done !== (g >= 20003) || fc2_done !== (g >= 20256)) errFlags++;

         if (g == 39) checkOutput("fc1_raddr_39", 32'(sram_raddr_in), 32'd39);
         if (g == 40) begin
            checkOutput("fc1_raddr_wrap", 32'(sram_raddr_in), 32'd0);
            checkOutput("fc1_weight_40", 32'(sram_raddr_weight), 32'd40);
            checkOutput("fc1_mac_last_n0", 32'({mac_valid, mac_last}), 32'b11);
         end
         if (g == 42) begin
            checkOutput("wb_n0_we", 32'(sram_write_enable_e), 32'b11110);
            checkOutput("wb_n0_waddr", 32'(sram_waddr_e), 32'd0);
            checkOutput("wb_n0_mask", 32'(sram_bytemask_e), 32'b0111);
         end
         if (g == 962) begin
            checkOutput("wb_n23_we", 32'(sram_write_enable_e), 32'b11110);
            checkOutput("wb_n23_waddr", 32'(sram_waddr_e), 32'd1);
            checkOutput("wb_n23_mask", 32'(sram_bytemask_e), 32'b1110);
         end
         if (g == 19999) checkOutput("fc1_weight_max", 32'(sram_raddr_weight), 32'd19999);
         if (g == 20002) begin
            checkOutput("wb_n499_we", 32'(sram_write_enable_e), 32'b01111);
            checkOutput("wb_n499_waddr", 32'(sram_waddr_e), 32'd24);
            checkOutput("wb_n499_mask", 32'(sram_bytemask_e), 32'b1110);
            checkOutput("fc1_done_before_fc2", 32'(fc1_done), 32'd0);
         end
         if (g == 20003) begin
            checkOutput("fc2_first_weight", 32'(sram_raddr_weight), 32'd20000);
            checkOutput("fc2_in_sel", 32'(in_sel), 32'd2);
            checkOutput("fc1_done_rise", 32'(fc1_done), 32'd1);
         end
         if (g == 20252) checkOutput("fc2_last_weight", 32'(sram_raddr_weight), 32'd20249);
         if (g == 20255) begin
            checkOutput("wb_f_n9_we", 32'(sram_write_enable_f), 32'd0);
            checkOutput("wb_f_n9_waddr", 32'(sram_waddr_f), 32'd2);
            checkOutput("wb_f_n9_mask", 32'(sram_bytemask_f), 32'b1011);
         end

         // Start pulses while running must be ignored.
         conv_done = (g == 100 || g == 20100);
         tick();
      end
      conv_done = 1'b0;

      checkOutput("run_addr_errors", 32'(errAddr), 32'd0);
      checkOutput("run_mac_errors", 32'(errMac), 32'd0);
      checkOutput("run_write_errors", 32'(errWr), 32'd0);
      checkOutput("run_flag_errors", 32'(errFlags), 32'd0);
      checkOutput("e_write_count", 32'(nWrE), 32'd500);
      checkOutput("f_write_count", 32'(nWrF), 32'd10);
      checkOutput("done_levels_held", 32'({fc1_done, fc2_done, busy}), 32'b110);
`ifdef FC_PERF_CNT_EN
      checkOutput("perf_cycles_run", perf_cycles, 32'd20256);
`endif

      // Restart from bank group d: done flags clear, in_sel selects d.
      applyStimulus(1'b1, 1'b0);
      conv_done = 1'b0;
      checkOutput("restart_in_sel", 32'(in_sel), 32'd1);
      checkOutput("restart_dones", 32'({fc1_done, fc2_done}), 32'd0);
      checkOutput("restart_busy", 32'(busy), 32'd1);
      checkOutput("restart_weight", 32'(sram_raddr_weight), 32'd0);
`ifdef FC_PERF_CNT_EN
      checkOutput("perf_cleared", perf_cycles, 32'd0);
`endif
      repeat (41) tick();
      checkOutput("restart_raddr_41", 32'(sram_raddr_in), 32'd1);
      checkOutput("restart_weight_41", 32'(sram_raddr_weight), 32'd41);

      // Reset lands just before neuron 0's writeback; that write must never appear.
      srst = 1'b1;
      tick();
      checkResetState("midrun_rst1");
      tick();
      checkResetState("midrun_rst2");
      srst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (sram_write_enable_e !== 5'h1F || sram_write_enable_f !== 1'b1 || busy !== 1'b0) errIdle++;
      end
      checkOutput("post_reset_idle_errors", 32'(errIdle), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
